// File: rtl/clint_pkg.sv
// Shared register-map constants, decode kinds and byte-merge helper for the CLINT timer.
package clint_pkg;

  localparam logic [15:0] MSIP_BASE = 16'h0000;
  localparam logic [15:0] CMP_BASE  = 16'h4000;
  localparam logic [15:0] CTRL      = 16'hBFF0;
  localparam logic [15:0] MTIME_LO  = 16'hBFF8;
  localparam logic [15:0] MTIME_HI  = 16'hBFFC;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_CTRL,
    REG_MTIME_LO,
    REG_MTIME_HI
  } reg_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
    logic [31:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (mask[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/clint_hart_channel.sv
// Per-hart state: mtimecmp with byte-masked writes, coherent-read high shadow, msip
// and the registered timer comparator.
module clint_hart_channel
  import clint_pkg::*;
#(
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] mtime,
  input  logic        wr_msip,
  input  logic        wr_cmp_lo,
  input  logic        wr_cmp_hi,
  input  logic        rd_cmp_lo,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  output logic [31:0] cmp_lo,
  output logic [31:0] cmp_shadow,
  output logic        msip,
  output logic        irq_timer
);

  logic [63:0] mtimecmp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp   <= CMP_RESET;
      cmp_shadow <= '0;
      msip       <= 1'b0;
      irq_timer  <= 1'b0;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0], wdata, wmask);
      if (wr_cmp_hi) mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], wdata, wmask);
      if (wr_msip && wmask[0]) msip <= wdata[0];
      if (rd_cmp_lo) cmp_shadow <= mtimecmp[63:32];
      // Compares pre-edge register values, so the level trails any update by one cycle.
      irq_timer <= (mtime >= mtimecmp);
    end
  end

  assign cmp_lo = mtimecmp[31:0];

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: free-running 64-bit mtime with prescaler, address decode,
// read mux and one clint_hart_channel per hart.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned HARTS     = 1,
  parameter int unsigned PRESC_W   = 8,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             mem_valid,
  input  logic             mem_write,
  input  logic [3:0]       mem_wmask,
  input  logic [31:0]      mem_wdata,
  input  logic [15:0]      mem_addr,
  output logic [31:0]      mem_rdata,
  output logic [HARTS-1:0] irq_timer,
  output logic [HARTS-1:0] irq_soft
);

  logic [15:0]        waddr;
  logic               wr_en;
  logic               rd_en;
  reg_e               kind;
  logic [3:0]         hart;
  logic [63:0]        mtime;
  logic [31:0]        mtime_shadow;
  logic               enable;
  logic [PRESC_W-1:0] div;
  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;
  logic [31:0]        ctrl_word;
  logic [31:0]        ctrl_next;
  logic [31:0]        rdata_next;
  logic [31:0]        ch_cmp_lo  [HARTS];
  logic [31:0]        ch_shadow  [HARTS];
  logic               unused_bits;

  assign waddr       = {mem_addr[15:2], 2'b00};
  assign wr_en       = sel & mem_valid & mem_write;
  assign rd_en       = sel & mem_valid & ~mem_write;
  assign tick        = enable && (presc_cnt == div);
  assign ctrl_word   = 32'({div, enable});
  assign ctrl_next   = byte_merge(ctrl_word, mem_wdata, mem_wmask);
  assign unused_bits = ^{mem_addr[1:0], ctrl_next};

  always_comb begin
    kind = REG_NONE;
    hart = '0;
    if (waddr == CTRL) begin
      kind = REG_CTRL;
    end else if (waddr == MTIME_LO) begin
      kind = REG_MTIME_LO;
    end else if (waddr == MTIME_HI) begin
      kind = REG_MTIME_HI;
    end else if (waddr < CMP_BASE) begin
      if ({2'b00, waddr[15:2]} < 16'(HARTS)) begin
        kind = REG_MSIP;
        hart = waddr[5:2];
      end
    end else if (waddr < CMP_BASE + 16'(8 * HARTS)) begin
      kind = waddr[2] ? REG_CMP_HI : REG_CMP_LO;
      hart = waddr[6:3];
    end
  end

  always_comb begin
    rdata_next = '0;
    case (kind)
      REG_CTRL:     rdata_next = ctrl_word;
      REG_MTIME_LO: rdata_next = mtime[31:0];
      REG_MTIME_HI: rdata_next = mtime_shadow;
      default: begin
        for (int unsigned h = 0; h < HARTS; h++) begin
          if (hart == 4'(h)) begin
            if (kind == REG_MSIP)   rdata_next = {31'b0, irq_soft[h]};
            if (kind == REG_CMP_LO) rdata_next = ch_cmp_lo[h];
            if (kind == REG_CMP_HI) rdata_next = ch_shadow[h];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime        <= '0;
      mtime_shadow <= '0;
      enable       <= 1'b1;
      div          <= '0;
      presc_cnt    <= '0;
      mem_rdata    <= '0;
    end else begin
      if (wr_en && kind == REG_CTRL) begin
        enable    <= ctrl_next[0];
        div       <= ctrl_next[PRESC_W:1];
        presc_cnt <= '0;
      end else if (enable) begin
        presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
      end

      // A software write to either half suppresses that cycle's increment entirely.
      if (wr_en && kind == REG_MTIME_LO) begin
        mtime[31:0] <= byte_merge(mtime[31:0], mem_wdata, mem_wmask);
      end else if (wr_en && kind == REG_MTIME_HI) begin
        mtime[63:32] <= byte_merge(mtime[63:32], mem_wdata, mem_wmask);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      if (rd_en) begin
        mem_rdata <= rdata_next;
        if (kind == REG_MTIME_LO) mtime_shadow <= mtime[63:32];
      end
    end
  end

  for (genvar h = 0; h < HARTS; h++) begin : g_hart
    clint_hart_channel #(
      .CMP_RESET(CMP_RESET)
    ) u_channel (
      .clk       (clk),
      .rst       (rst),
      .mtime     (mtime),
      .wr_msip   (wr_en && kind == REG_MSIP   && hart == 4'(h)),
      .wr_cmp_lo (wr_en && kind == REG_CMP_LO && hart == 4'(h)),
      .wr_cmp_hi (wr_en && kind == REG_CMP_HI && hart == 4'(h)),
      .rd_cmp_lo (rd_en && kind == REG_CMP_LO && hart == 4'(h)),
      .wmask     (mem_wmask),
      .wdata     (mem_wdata),
      .cmp_lo    (ch_cmp_lo[h]),
      .cmp_shadow(ch_shadow[h]),
      .msip      (irq_soft[h]),
      .irq_timer (irq_timer[h])
    );
  end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer (HARTS=2): reads are scored against a queue of
// hand-computed values by a monitor; interrupt levels are checked directly.
module tb_clint_timer;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        mem_valid;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [1:0]  irq_timer;
  logic [1:0]  irq_soft;

  typedef struct {
    string       name;
    logic [31:0] exp;
    int unsigned tol;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  clint_timer #(
    .HARTS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .mem_valid(mem_valid),
    .mem_write(mem_write),
    .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .irq_timer(irq_timer),
    .irq_soft (irq_soft)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: a read accepted at a rising edge presents mem_rdata just after it.
  initial begin
    sb_t         e;
    logic [31:0] diff;
    forever begin
      @(posedge clk);
      if (!rst && sel && mem_valid && !mem_write) begin
        #1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rdata_unexpected: got %h, no expected value queued", mem_rdata);
        end else begin
          e    = sb.pop_front();
          diff = (mem_rdata > e.exp) ? mem_rdata - e.exp : e.exp - mem_rdata;
          if (diff > e.tol) begin
            errors++;
            $display("FAIL %s: got %h expected %h (tol %0d)", e.name, mem_rdata, e.exp, e.tol);
          end
        end
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
    sel = 1'b1; mem_valid = 1'b1; mem_write = 1'b1;
    mem_addr = a; mem_wdata = d; mem_wmask = m;
    @(negedge clk);
    sel = 1'b0; mem_valid = 1'b0; mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [31:0] e,
                          input int unsigned tol, input string nm);
    sb.push_back('{nm, e, tol});
    sel = 1'b1; mem_valid = 1'b1; mem_write = 1'b0;
    mem_addr = a; mem_wmask = 4'h0;
    @(negedge clk);
    sel = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; mem_valid = 1'b0; mem_write = 1'b0;
    mem_wmask = 4'h0; mem_wdata = '0; mem_addr = '0;

    idle(2);
    check("reset_rdata", mem_rdata, 32'h0);
    check("reset_irq_timer", 32'(irq_timer), 32'h0);
    check("reset_irq_soft", 32'(irq_soft), 32'h0);
    rst = 1'b0;

    // Free run with D=0: mtime tracks the cycle count.
    idle(9);
    bus_read(16'hBFF8, 32'd10, 1, "mtime_cycle10");
    check("irq_timer_at_cmp_reset", 32'(irq_timer), 32'h0);

    // D=3: one increment per four cycles.
    bus_write(16'hBFF0, 32'h7, 4'hF);
    bus_write(16'hBFF8, 32'h100, 4'hF);
    for (int k = 0; k < 3; k++) begin
      idle(3);
      bus_read(16'hBFF8, 32'h101 + 32'(k), 0, "presc_div4");
    end
    bus_write(16'hBFF0, 32'h6, 4'hF);
    bus_read(16'hBFF0, 32'h6, 0, "ctrl_readback");
    bus_read(16'hBFF8, 32'h103, 0, "frozen_start");
    idle(20);
    bus_read(16'hBFF8, 32'h103, 0, "frozen_after20");

    // Coherent high read across a low-word carry.
    bus_write(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    bus_write(16'hBFFC, 32'h0, 4'hF);
    bus_write(16'hBFF0, 32'h1, 4'hF);
    bus_read(16'hBFF8, 32'hFFFF_FFFE, 0, "coh_lo");
    idle(2);
    bus_read(16'hBFFC, 32'h0, 0, "coh_hi_shadow");
    bus_read(16'hBFF8, 32'h2, 0, "carry_lo");
    bus_read(16'hBFFC, 32'h1, 0, "carry_hi");

    // Compare on hart 1.
    bus_write(16'hBFF0, 32'h0, 4'hF);
    bus_write(16'hBFFC, 32'h0, 4'hF);
    bus_write(16'hBFF8, 32'h10, 4'hF);
    bus_write(16'h4008, 32'h20, 4'hF);
    bus_write(16'h400C, 32'h0, 4'hF);
    idle(1);
    check("irq_below_cmp", 32'(irq_timer), 32'h0);
    bus_write(16'hBFF0, 32'h1, 4'hF);
    idle(16);
    check("irq_at_reach_edge", 32'(irq_timer), 32'h0);
    idle(1);
    check("irq_rise", 32'(irq_timer), 32'h2);
    bus_write(16'h4008, 32'h100, 4'hF);
    check("irq_hold_after_raise", 32'(irq_timer), 32'h2);
    idle(1);
    check("irq_fall", 32'(irq_timer), 32'h0);

    // Partial write colliding with a tick: mtime is 0x23 before this edge.
    bus_write(16'hBFF8, 32'hAABB_CCDD, 4'b0010);
    bus_read(16'hBFF8, 32'h0000_CC23, 0, "mask_collision");

    // msip, out-of-range harts and unmapped space.
    bus_write(16'h0004, 32'h1, 4'hF);
    check("msip1_set", 32'(irq_soft), 32'h2);
    bus_write(16'h0008, 32'h1, 4'hF);
    check("msip2_ignored", 32'(irq_soft), 32'h2);
    bus_read(16'h0008, 32'h0, 0, "msip2_read");
    bus_read(16'h0004, 32'h1, 0, "msip1_read");
    bus_read(16'h2000, 32'h0, 0, "unmapped_read");
    bus_read(16'h4010, 32'h0, 0, "cmp2_read");
    bus_read(16'h4008, 32'h100, 0, "cmp1_lo_read");
    bus_read(16'h4000, 32'hFFFF_FFFF, 0, "cmp0_lo_read");
    bus_read(16'h4004, 32'hFFFF_FFFF, 0, "cmp0_hi_shadow");
    check("irq_before_reset", 32'(irq_timer), 32'h2);

    // Asynchronous reset mid-count.
    rst = 1'b1;
    #1;
    check("async_rst_rdata", mem_rdata, 32'h0);
    check("async_rst_irq_timer", 32'(irq_timer), 32'h0);
    check("async_rst_irq_soft", 32'(irq_soft), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(16'hBFF8, 32'h0, 0, "post_rst_mtime_lo");
    bus_read(16'hBFFC, 32'h0, 0, "post_rst_mtime_hi");

    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d reads never presented", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Parametrised core-local interruptor for HARTS harts; replaces the ad-hoc mtime/mtimecmp logic in the simulation wrappers with one synthesizable block.
- Holds a 64-bit free-running mtime with programmable prescaler, per-hart 64-bit mtimecmp and per-hart software-interrupt bit.
- Drives per-hart timer and software interrupts.
- Sits on the pipeline data bus behind the top-level address decoder.

Parameters:
- HARTS, 1, number of harts/channels (1..16)
- PRESC_W, 8, width of prescaler divisor field
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of every mtimecmp

Ports:
- clk  in  1  clock, sole clock domain
- rst  in  1  asynchronous active-high reset
- sel  in  1  decoder hit: access targets this block
- mem_valid  in  1  bus request valid
- mem_write  in  1  1 = write, 0 = read
- mem_wmask  in  4  byte enables for write
- mem_wdata  in  32  write data
- mem_addr  in  16  byte offset within block (bits 1:0 ignored)
- mem_rdata  out  32  read data, registered, valid cycle after request
- irq_timer  out  HARTS  per-hart timer interrupt, registered
- irq_soft  out  HARTS  per-hart software interrupt (msip bit 0)

Behaviour:
- Register map (word offsets):
  - 0x0000+4h: msip[h], bit 0 only; other bits read 0.
  - 0x4000+8h: mtimecmp[h] low word.
  - 0x4004+8h: mtimecmp[h] high word.
  - 0xBFF0: ctrl. Bit 0 = enable. Bits PRESC_W:1 = divisor D.
  - 0xBFF8: mtime low word.
  - 0xBFFC: mtime high word.
  - Unmapped offsets and h >= HARTS: read 0, writes ignored.
- Reset values: mtime 0; mtimecmp = CMP_RESET; msip 0; enable 1; D 0; prescale counter 0; hi shadow 0; mem_rdata 0; irq_timer 0; irq_soft 0.
- Writes:
  - Accepted when sel & mem_valid & mem_write.
  - Byte-granular per mem_wmask; a partial write updates only the enabled bytes.
  - Take effect at the clock edge of the request.
- Reads:
  - Accepted when sel & mem_valid & !mem_write.
  - mem_rdata is registered and presented the next cycle.
  - It holds its value until the next accepted read; non-selected cycles do not alter it.
- Coherent 64-bit read:
  - Reading mtime low captures the current mtime[63:32] into a shadow register in the same edge.
  - A following read of mtime high returns the shadow, not the live value.
  - The shadow is recaptured on every low read.
  - The same scheme applies independently to each mtimecmp[h] (per-hart shadow).
- Prescaler:
  - When enable = 1, counter counts 0..D. A tick fires when counter == D; counter then wraps to 0.
  - D = 0 means a tick every cycle.
  - When enable = 0, counter and mtime freeze.
  - A write to ctrl clears the counter.
- mtime increment:
  - On tick, mtime <= mtime + 1, full 64-bit with carry.
  - 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write/tick collision: a write to either mtime half in the same cycle as a tick wins. Written bytes take the write value, unwritten bytes keep the pre-increment value, and there is no increment that cycle.
- Compare:
  - irq_timer[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit.
  - Evaluated on register values after the edge, so irq_timer changes one cycle after the mtime/mtimecmp update.
  - Level-sensitive; cleared only by raising mtimecmp or rewinding mtime.
- irq_soft[h] is msip[h] directly (registered state, no extra delay).
- Reset mid-operation: all state returns to reset values asynchronously; a pending read returns 0.

Decomposition:
- Shared package clint_pkg:
  - Offset constants: MSIP_BASE 0x0000, CMP_BASE 0x4000, CTRL 0xBFF0, MTIME_LO 0xBFF8, MTIME_HI 0xBFFC.
  - Byte-mask merge function (old, new, mask) -> merged word.
- Sub-module clint_hart_channel, instantiated HARTS times. It contains:
  - mtimecmp with byte-masked write
  - high shadow
  - msip
  - comparator and irq registers
- The top holds mtime, the prescaler, ctrl, address decode and the read mux.

Test Plan:
- Reset, D=0, enable=1:
  - read 0xBFF8 at cycle 10 after reset release -> value within 1 of the cycle count.
  - irq_timer = 0 with mtimecmp at CMP_RESET.
- Write ctrl = {D=3, en=1} -> mtime increments exactly once per 4 cycles.
  - Write ctrl en=0 -> mtime constant over 20 cycles.
- Hi-word coherence:
  - Write mtime = 0x0000_0000_FFFF_FFFE, D=0.
  - Read low, then high 3 cycles later -> high = 0x0 (shadow), although live high is now 1.
- Compare, HARTS=2:
  - mtimecmp[1] = 0x20, mtime = 0x10 -> irq_timer = 2'b00.
  - irq_timer[1] rises one cycle after mtime reaches 0x20; irq_timer[0] stays 0.
  - Write mtimecmp[1] = 0x100 -> irq_timer[1] falls next cycle.
- Byte mask and collision:
  - Write 0xBFF8 with wdata 0xAABBCCDD, wmask 4'b0010, on a tick cycle.
  - Result: mtime low byte 1 = 0xCC, other bytes equal the pre-tick value, no increment that cycle.
- msip and reset:
  - Write 0x0004 = 1 -> irq_soft = 2'b10.
  - Write 0x0008 (h=2 ≥ HARTS) -> no change, read returns 0.
  - Assert rst mid-count -> all outputs 0 immediately, mtime 0.
